// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet sequencer.
// State codes and PE instruction encodings.
package corelet_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t W_FETCH  = 3'd1;
  localparam state_t W_LOAD   = 3'd2;
  localparam state_t W_FLUSH  = 3'd3;
  localparam state_t A_STREAM = 3'd4;
  localparam state_t DRAIN    = 3'd5;
  localparam state_t DONE     = 3'd6;

  typedef logic [1:0] inst_t;

  localparam inst_t INST_IDLE  = 2'b00;
  localparam inst_t INST_KLOAD = 2'b01;
  localparam inst_t INST_EXEC  = 2'b10;

endpackage

// File: rtl/corelet_ctrl_fetch_unit.sv
// xmem -> L0 fetch engine: address count, full gating and the
// one-cycle write delay matching xmem read latency.
module ctrl_fetch_unit
  import corelet_pkg::*;
#(
  parameter int addr_bw = 11,
  parameter int cw      = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               guard,
  input  logic [addr_bw-1:0] base,
  input  logic [cw-1:0]      count,
  input  logic               l0_full,
  output logic               xmem_rd,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               l0_wr,
  output logic               idle
);

  logic [cw-1:0] cnt;
  logic          wr_q;
  logic          full_q;
  logic          stall;

  // While streaming, hold off one extra cycle after full drops so the
  // write already in flight is reflected in l0_full before reissuing.
  assign stall = l0_full || (guard && full_q);

  assign xmem_rd   = en && (cnt != count) && !stall;
  assign xmem_addr = xmem_rd ? base + addr_bw'(cnt) : '0;
  assign l0_wr     = wr_q;
  assign idle      = (cnt == count) && !wr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      wr_q   <= 1'b0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= xmem_rd;
      full_q <= l0_full;
      if (!en)
        cnt <= '0;
      else if (xmem_rd)
        cnt <= cnt + cw'(1);
    end
  end

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: weight fetch/load, flush, activation stream
// and psum drain for one weight-stationary tile per start pulse.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  output logic               busy,
  output logic               done,
  output logic               xmem_rd,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  input  logic               l0_full,
  input  logic               l0_ready,
  output logic [1:0]         inst_w,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               pmem_wr,
  output logic [addr_bw-1:0] pmem_addr
);

  localparam int CW = len_bw + 1;
  localparam int FW = $clog2(row + col + 1);

  state_t            state;
  state_t            state_nx;
  logic [len_bw-1:0] len_q;
  logic [CW-1:0]     ei;
  logic [CW-1:0]     oi;
  logic [FW-1:0]     fi;
  inst_t             inst_q;
  logic              pmem_wr_q;

  logic               stream;
  logic               fetch_on;
  logic               drain_on;
  logic               fu_idle;
  logic [CW-1:0]      len_x;
  logic [CW-1:0]      wr_tot;
  logic [CW-1:0]      fu_count;
  logic [addr_bw-1:0] fu_base;

  assign len_x    = {1'b0, len_q};
  assign stream   = state == A_STREAM;
  assign fetch_on = (state == W_FETCH) || stream;
  assign drain_on = stream || (state == DRAIN);
  assign fu_base  = stream ? addr_bw'(col) : '0;
  assign fu_count = stream ? len_x : CW'(col);

  ctrl_fetch_unit #(
    .addr_bw (addr_bw),
    .cw      (CW)
  ) u_fetch (
    .clk       (clk),
    .reset     (reset),
    .en        (fetch_on),
    .guard     (stream),
    .base      (fu_base),
    .count     (fu_count),
    .l0_full   (l0_full),
    .xmem_rd   (xmem_rd),
    .xmem_addr (xmem_addr),
    .l0_wr     (l0_wr),
    .idle      (fu_idle)
  );

  assign l0_rd = l0_ready &&
    (((state == W_LOAD) && (ei < CW'(col))) ||
     (stream && (ei < len_x)));

  // Count the psum write in flight so the OFIFO is never over-popped.
  assign wr_tot    = oi + CW'(pmem_wr_q);
  assign ofifo_rd  = drain_on && ofifo_valid && (wr_tot < len_x);
  assign pmem_wr   = pmem_wr_q;
  assign pmem_addr = pmem_wr_q ? addr_bw'(oi) : '0;

  assign inst_w = inst_q;
  assign busy   = state != IDLE;
  assign done   = state == DONE;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start && (len != '0)) state_nx = W_FETCH;
      W_FETCH:  if (fu_idle) state_nx = W_LOAD;
      W_LOAD:   if (ei == CW'(col)) state_nx = W_FLUSH;
      W_FLUSH:  if (fi == FW'(row + col - 1)) state_nx = A_STREAM;
      A_STREAM: if (ei == len_x) state_nx = DRAIN;
      DRAIN:    if (wr_tot == len_x) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      ei        <= '0;
      oi        <= '0;
      fi        <= '0;
      inst_q    <= INST_IDLE;
      pmem_wr_q <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && (state_nx == W_FETCH))
        len_q <= len;
      if (state_nx != state)
        ei <= '0;
      else if (l0_rd)
        ei <= ei + CW'(1);
      if (state_nx != state)
        fi <= '0;
      else if (state == W_FLUSH)
        fi <= fi + FW'(1);
      if (!drain_on)
        oi <= '0;
      else if (pmem_wr_q)
        oi <= oi + CW'(1);
      if (!l0_rd)
        inst_q <= INST_IDLE;
      else
        inst_q <= stream ? INST_EXEC : INST_KLOAD;
      pmem_wr_q <= ofifo_rd;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl with L0 and OFIFO models.
// Tiles, backpressure, slow OFIFO, ignored starts, mid-tile reset.
module tb_corelet_ctrl;

  localparam int COL   = 8;
  localparam int ROW   = 8;
  localparam int AW    = 11;
  localparam int LW    = 8;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len   = '0;

  logic          busy;
  logic          done;
  logic          xmem_rd;
  logic [AW-1:0] xmem_addr;
  logic          l0_wr;
  logic          l0_rd;
  logic          l0_full;
  logic          l0_ready;
  logic [1:0]    inst_w;
  logic          ofifo_valid;
  logic          ofifo_rd;
  logic          pmem_wr;
  logic [AW-1:0] pmem_addr;

  int checks   = 0;
  int failures = 0;

  logic        force_full = 1'b0;
  logic        slow       = 1'b0;
  logic        tog        = 1'b0;
  int          l0_cnt     = 0;
  int          avail      = 0;
  logic [15:0] exec_sr    = '0;

  always #5 clk = ~clk;

  corelet_ctrl #(
    .col     (COL),
    .row     (ROW),
    .addr_bw (AW),
    .len_bw  (LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .xmem_rd     (xmem_rd),
    .xmem_addr   (xmem_addr),
    .l0_wr       (l0_wr),
    .l0_rd       (l0_rd),
    .l0_full     (l0_full),
    .l0_ready    (l0_ready),
    .inst_w      (inst_w),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .pmem_wr     (pmem_wr),
    .pmem_addr   (pmem_addr)
  );

  assign l0_ready    = l0_cnt != 0;
  assign l0_full     = force_full || (l0_cnt >= DEPTH);
  assign ofifo_valid = (avail != 0) && (!slow || tog);

  // psum row appears row+col cycles after its execute pulse
  always @(posedge clk) begin
    if (!reset) begin
      l0_cnt  <= 0;
      avail   <= 0;
      exec_sr <= '0;
      tog     <= 1'b0;
    end else begin
      l0_cnt  <= l0_cnt + int'(l0_wr) - int'(l0_rd);
      exec_sr <= {exec_sr[14:0], inst_w == 2'b10};
      avail   <= avail + int'(exec_sr[15]) - int'(ofifo_rd);
      tog     <= ~tog;
    end
  end

  int cyc        = 0;
  int nkl        = 0;
  int nex        = 0;
  int nbad       = 0;
  int ndone      = 0;
  int xviol      = 0;
  int oviol      = 0;
  int ovf        = 0;
  int last_kl    = -1;
  int first_col  = -1;
  int wr_at_done = -1;
  logic [AW-1:0] xq[$];
  logic [AW-1:0] pq[$];

  always @(negedge clk) begin
    cyc++;
    if (xmem_rd) begin
      xq.push_back(xmem_addr);
      if (l0_full) xviol++;
      if (xmem_addr == AW'(COL) && first_col < 0) first_col = cyc;
    end
    if (inst_w == 2'b01) begin
      nkl++;
      last_kl = cyc;
    end
    if (inst_w == 2'b10) nex++;
    if (inst_w == 2'b11) nbad++;
    if (ofifo_rd && !ofifo_valid) oviol++;
    if (l0_wr && !l0_rd && l0_cnt >= DEPTH) ovf++;
    if (pmem_wr) pq.push_back(pmem_addr);
    if (done) begin
      ndone++;
      wr_at_done = pq.size();
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int n);
    start = 1'b1;
    len   = LW'(n);
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic clear_mon();
    xq.delete();
    pq.delete();
    nkl        = 0;
    nex        = 0;
    nbad       = 0;
    ndone      = 0;
    xviol      = 0;
    oviol      = 0;
    ovf        = 0;
    last_kl    = -1;
    first_col  = -1;
    wr_at_done = -1;
  endtask

  function automatic int outs();
    return int'({done, xmem_rd, l0_wr, l0_rd, ofifo_rd,
                 pmem_wr, inst_w, xmem_addr, pmem_addr});
  endfunction

  task automatic wait_done(input string t, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk({t, "_done_seen"}, got, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_stream(input string t);
    for (int i = 0; i < 300 && first_col < 0; i++) tick();
    chk({t, "_stream_seen"}, int'(first_col >= 0), 1);
  endtask

  // xmem addresses are 0..col-1 then col..col+n-1, i.e. simply i
  task automatic check_tile(input string t, input int n);
    int e;
    e = 0;
    chk({t, "_xn"}, xq.size(), COL + n);
    foreach (xq[i]) if (int'(xq[i]) != i) e++;
    chk({t, "_xseq"}, e, 0);
    chk({t, "_kload"}, nkl, COL);
    chk({t, "_exec"}, nex, n);
    chk({t, "_inst11"}, nbad, 0);
    e = 0;
    chk({t, "_pn"}, pq.size(), n);
    foreach (pq[i]) if (int'(pq[i]) != i) e++;
    chk({t, "_pseq"}, e, 0);
    chk({t, "_ndone"}, ndone, 1);
    chk({t, "_wr_at_done"}, wr_at_done, n);
    chk({t, "_rd_full"}, xviol, 0);
    chk({t, "_rd_novalid"}, oviol, 0);
    chk({t, "_l0_ovf"}, ovf, 0);
    chk({t, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", outs(), 0);
    reset = 1'b1;
    tick();

    clear_mon();
    kick(4);
    wait_done("basic", 600);
    check_tile("basic", 4);
    chk("flush_gap", first_col - last_kl - 1, ROW + COL);

    clear_mon();
    kick(0);
    repeat (5) tick();
    @(negedge clk);
    chk("len0_busy", int'(busy), 0);
    chk("len0_xrd", xq.size(), 0);

    clear_mon();
    kick(4);
    repeat (10) tick();
    kick(7);
    wait_done("bstart", 600);
    check_tile("bstart", 4);

    clear_mon();
    kick(36);
    repeat (2) tick();
    force_full = 1'b1;
    repeat (5) tick();
    force_full = 1'b0;
    wait_stream("bp");
    repeat (3) tick();
    force_full = 1'b1;
    repeat (5) tick();
    force_full = 1'b0;
    wait_done("bp", 2000);
    check_tile("bp", 36);

    slow = 1'b1;
    clear_mon();
    kick(36);
    wait_done("slow", 3000);
    check_tile("slow", 36);
    slow = 1'b0;

    clear_mon();
    kick(36);
    wait_stream("mrst");
    repeat (3) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("mrst_outs", outs(), 0);
    chk("mrst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (40) tick();
    chk("mrst_nodone", ndone, 0);

    clear_mon();
    kick(4);
    wait_done("after", 600);
    check_tile("after", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
